// File: rtl/logic_pipe_pkg.sv
// ============================================================================
// logic_pipe_pkg : op encodings and per-bit logic function for logic_pipe_reg
// Rev 1.0
// ============================================================================
`default_nettype none

package logic_pipe_pkg;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;

  // Single-bit form so callers of any width can apply it bitwise.
  function automatic logic logic_fn(input logic a, input logic b, input logic [1:0] op);
    logic r;
    r = 1'b0;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      default: r = ~(a & b);
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/logic_pipe_reg_if.sv
// ============================================================================
// logic_pipe_reg_if : producer/consumer handshake bundle for logic_pipe_reg
// Rev 1.0
// ============================================================================
`default_nettype none

interface logic_pipe_reg_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       op;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] q;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] zero_cnt;

  modport master (
    output a, b, op, in_valid, out_ready,
    input  in_ready, q, out_valid, zero_cnt
  );

  modport slave (
    input  a, b, op, in_valid, out_ready,
    output in_ready, q, out_valid, zero_cnt
  );
endinterface

`default_nettype wire

// File: rtl/logic_pipe_stage.sv
// ============================================================================
// logic_pipe_stage : one elastic register slot (data + valid) with valid/ready
// Rev 1.0
// ============================================================================
`default_nettype none

module logic_pipe_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid_i,
  output logic             up_ready_o,
  input  logic [WIDTH-1:0] up_data_i,
  output logic             dn_valid_o,
  input  logic             dn_ready_i,
  output logic [WIDTH-1:0] dn_data_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q,  data_d;

  // Empty slots load even under downstream stall, so bubbles collapse.
  assign up_ready_o = !valid_q || dn_ready_i;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (up_ready_o) begin
      valid_d = up_valid_i;
      if (up_valid_i) begin
        data_d = up_data_i;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign dn_valid_o = valid_q;
  assign dn_data_o  = data_q;

endmodule

`default_nettype wire

// File: rtl/logic_pipe_reg.sv
// ============================================================================
// logic_pipe_reg : bitwise AND/OR/XOR/NAND through STAGES elastic registers,
//                  with a saturating count of delivered all-zero results
// Rev 1.0
// ============================================================================
`default_nettype none

module logic_pipe_reg #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  logic_pipe_reg_if.slave   bus
);
  import logic_pipe_pkg::*;

  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  logic [WIDTH-1:0] w_res;
  logic             w_valid [STAGES+1];
  logic             w_ready [STAGES+1];
  logic [WIDTH-1:0] w_data  [STAGES+1];
  logic             w_zero_hit;
  logic [CNT_W-1:0] zero_cnt_q, zero_cnt_d;

  always_comb begin
    w_res = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_res[i] = logic_fn(bus.a[i], bus.b[i], bus.op);
    end
  end

  assign w_valid[0]      = bus.in_valid;
  assign w_data[0]       = w_res;
  assign w_ready[STAGES] = bus.out_ready;

  // Ready ripples combinationally from the consumer back to the producer.
  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic_pipe_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk        (clk),
      .rst        (rst),
      .up_valid_i (w_valid[i]),
      .up_ready_o (w_ready[i]),
      .up_data_i  (w_data[i]),
      .dn_valid_o (w_valid[i+1]),
      .dn_ready_i (w_ready[i+1]),
      .dn_data_o  (w_data[i+1])
    );
  end

  assign w_zero_hit = w_valid[STAGES] && bus.out_ready && (w_data[STAGES] == '0);

  always_comb begin
    zero_cnt_d = zero_cnt_q;
    if (w_zero_hit && (zero_cnt_q != c_cnt_max)) begin
      zero_cnt_d = zero_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_cnt_q <= '0;
    end else begin
      zero_cnt_q <= zero_cnt_d;
    end
  end

  assign bus.in_ready  = w_ready[0];
  assign bus.q         = w_data[STAGES];
  assign bus.out_valid = w_valid[STAGES];
  assign bus.zero_cnt  = zero_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_logic_pipe_reg.sv
// ============================================================================
// tb_logic_pipe_reg : scoreboard bench for an 8-bit/2-stage/2-bit-counter build
//                     and a 1-bit/1-stage build of logic_pipe_reg
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_logic_pipe_reg;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  logic_pipe_reg_if #(.WIDTH(8), .CNT_W(2))  ifa ();
  logic_pipe_reg_if #(.WIDTH(1), .CNT_W(16)) ifb ();

  logic_pipe_reg #(.WIDTH(8), .STAGES(2), .CNT_W(2)) u_dut_a (
    .clk (clk), .rst (rst), .bus (ifa)
  );

  logic_pipe_reg #(.WIDTH(1), .STAGES(1), .CNT_W(16)) u_dut_b (
    .clk (clk), .rst (rst), .bus (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] qa [$];
  logic       qb [$];

  function automatic logic [7:0] model8(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

  // Scoreboard: expected results queued on acceptance, compared on delivery.
  always @(negedge clk) begin
    logic [7:0] ea;
    logic [7:0] eb;
    if (!rst) begin
      if (ifa.out_valid && ifa.out_ready) begin
        n_tests++;
        if (qa.size() == 0) begin
          n_fail++; $display("FAIL sb_a_extra: got q=%h, want no delivery", ifa.q);
        end else begin
          ea = qa.pop_front();
          if (ifa.q !== ea) begin n_fail++; $display("FAIL sb_a_data: got %h want %h", ifa.q, ea); end
        end
      end
      if (ifa.in_valid && ifa.in_ready) qa.push_back(model8(ifa.a, ifa.b, ifa.op));
      if (ifb.out_valid && ifb.out_ready) begin
        n_tests++;
        if (qb.size() == 0) begin
          n_fail++; $display("FAIL sb_b_extra: got q=%b, want no delivery", ifb.q);
        end else begin
          eb = {7'd0, qb.pop_front()};
          if (ifb.q !== eb[0]) begin n_fail++; $display("FAIL sb_b_data: got %b want %b", ifb.q, eb[0]); end
        end
      end
      if (ifb.in_valid && ifb.in_ready) begin
        eb = model8({7'd0, ifb.a}, {7'd0, ifb.b}, ifb.op);
        qb.push_back(eb[0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_tests += 5;
    if (ifa.q !== 8'h00)      begin n_fail++; $display("FAIL rst_q: got %h want 00", ifa.q); end
    if (ifa.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", ifa.out_valid); end
    if (ifa.in_ready !== 1'b1)  begin n_fail++; $display("FAIL rst_in_ready: got %b want 1", ifa.in_ready); end
    if (ifa.zero_cnt !== 2'd0)  begin n_fail++; $display("FAIL rst_zero_cnt: got %0d want 0", ifa.zero_cnt); end
    if (ifb.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_b_out_valid: got %b want 0", ifb.out_valid); end
    rst = 1'b0;
    tick();
    n_tests += 4;
    if (ifa.q !== 8'h00)      begin n_fail++; $display("FAIL rel_q: got %h want 00", ifa.q); end
    if (ifa.out_valid !== 1'b0) begin n_fail++; $display("FAIL rel_out_valid: got %b want 0", ifa.out_valid); end
    if (ifa.in_ready !== 1'b1)  begin n_fail++; $display("FAIL rel_in_ready: got %b want 1", ifa.in_ready); end
    if (ifa.zero_cnt !== 2'd0)  begin n_fail++; $display("FAIL rel_zero_cnt: got %0d want 0", ifa.zero_cnt); end
  endtask

  task automatic test_ops();
    logic [7:0] exp_tab [4];
    exp_tab = '{8'h30, 8'hFC, 8'hCC, 8'hCF};
    ifa.out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c < 4) begin
        ifa.in_valid = 1'b1; ifa.a = 8'hF0; ifa.b = 8'h3C; ifa.op = 2'(c);
        #1;
        n_tests++;
        if (ifa.in_ready !== 1'b1) begin n_fail++; $display("FAIL ops_in_ready[%0d]: got %b want 1", c, ifa.in_ready); end
      end else begin
        ifa.in_valid = 1'b0;
      end
      tick();
      n_tests++;
      if (ifa.out_valid !== (c >= 1 && c <= 4)) begin
        n_fail++; $display("FAIL ops_out_valid[%0d]: got %b want %b", c, ifa.out_valid, (c >= 1 && c <= 4));
      end
      if (c >= 1 && c <= 4) begin
        n_tests++;
        if (ifa.q !== exp_tab[c-1]) begin n_fail++; $display("FAIL ops_q[%0d]: got %h want %h", c, ifa.q, exp_tab[c-1]); end
      end
    end
  endtask

  task automatic test_backpressure();
    ifa.out_ready = 1'b0;
    ifa.b = 8'h0F; ifa.op = 2'b10;
    for (int i = 0; i < 3; i++) begin
      ifa.in_valid = 1'b1; ifa.a = 8'h10 + 8'(i);
      #1;
      n_tests++;
      if (ifa.in_ready !== (i < 2)) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b want %b", i, ifa.in_ready, (i < 2)); end
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      n_tests += 3;
      if (ifa.q !== 8'h1F)        begin n_fail++; $display("FAIL bp_hold_q[%0d]: got %h want 1f", k, ifa.q); end
      if (ifa.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", k, ifa.out_valid); end
      if (ifa.in_ready !== 1'b0)  begin n_fail++; $display("FAIL bp_hold_ready[%0d]: got %b want 0", k, ifa.in_ready); end
      tick();
    end
    ifa.out_ready = 1'b1;
    #1;
    n_tests++;
    if (ifa.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_full_pass: got in_ready=%b want 1", ifa.in_ready); end
    tick();
    ifa.in_valid = 1'b0;
    n_tests++;
    if (ifa.q !== 8'h1E) begin n_fail++; $display("FAIL bp_drain1: got %h want 1e", ifa.q); end
    tick();
    n_tests++;
    if (ifa.q !== 8'h1D) begin n_fail++; $display("FAIL bp_drain2: got %h want 1d", ifa.q); end
    tick();
    n_tests++;
    if (ifa.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got out_valid=%b want 0", ifa.out_valid); end
  endtask

  task automatic test_zero_count();
    logic [1:0] zexp [5];
    int n_del;
    int n_sent;
    logic del;
    logic acc;
    zexp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    n_tests++;
    if (ifa.zero_cnt !== 2'd0) begin n_fail++; $display("FAIL zc_start: got %0d want 0", ifa.zero_cnt); end
    ifa.out_ready = 1'b0;
    ifa.in_valid = 1'b1; ifa.a = 8'h0F; ifa.b = 8'hF0; ifa.op = 2'b00;
    tick();
    ifa.in_valid = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      n_tests += 2;
      if (ifa.out_valid !== 1'b1) begin n_fail++; $display("FAIL zc_stall_valid[%0d]: got %b want 1", k, ifa.out_valid); end
      if (ifa.zero_cnt !== 2'd0)  begin n_fail++; $display("FAIL zc_stall_cnt[%0d]: got %0d want 0", k, ifa.zero_cnt); end
      tick();
    end
    ifa.out_ready = 1'b1;
    n_del = 0; n_sent = 1;
    for (int cyc = 0; cyc < 12 && n_del < 5; cyc++) begin
      ifa.in_valid = (n_sent < 5);
      #1;
      del = ifa.out_valid && ifa.out_ready;
      acc = ifa.in_valid && ifa.in_ready;
      tick();
      if (acc) n_sent++;
      if (del) begin
        n_del++;
        n_tests++;
        if (ifa.zero_cnt !== zexp[n_del-1]) begin
          n_fail++; $display("FAIL zc_count[%0d]: got %0d want %0d", n_del, ifa.zero_cnt, zexp[n_del-1]);
        end
      end
    end
    ifa.in_valid = 1'b0;
    n_tests++;
    if (n_del != 5) begin n_fail++; $display("FAIL zc_deliveries: got %0d want 5", n_del); end
  endtask

  task automatic test_reset_mid();
    ifa.out_ready = 1'b0;
    ifa.in_valid = 1'b1; ifa.a = 8'hAA; ifa.b = 8'h55; ifa.op = 2'b10;
    tick();
    ifa.a = 8'h5A; ifa.b = 8'h0F; ifa.op = 2'b01;
    tick();
    ifa.in_valid = 1'b0;
    n_tests++;
    if (ifa.out_valid !== 1'b1) begin n_fail++; $display("FAIL rm_filled: got out_valid=%b want 1", ifa.out_valid); end
    #2;
    rst = 1'b1;
    #1;
    qa.delete();
    qb.delete();
    n_tests += 4;
    if (ifa.out_valid !== 1'b0) begin n_fail++; $display("FAIL rm_out_valid: got %b want 0", ifa.out_valid); end
    if (ifa.zero_cnt !== 2'd0)  begin n_fail++; $display("FAIL rm_zero_cnt: got %0d want 0", ifa.zero_cnt); end
    if (ifa.q !== 8'h00)        begin n_fail++; $display("FAIL rm_q: got %h want 00", ifa.q); end
    if (ifa.in_ready !== 1'b1)  begin n_fail++; $display("FAIL rm_in_ready: got %b want 1", ifa.in_ready); end
    tick();
    rst = 1'b0;
    ifa.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_tests++;
      if (ifa.out_valid !== 1'b0) begin n_fail++; $display("FAIL rm_stale[%0d]: got out_valid=%b want 0", k, ifa.out_valid); end
    end
    ifa.in_valid = 1'b1; ifa.a = 8'hC3; ifa.b = 8'h0F; ifa.op = 2'b00;
    tick();
    ifa.in_valid = 1'b0;
    tick();
    n_tests += 2;
    if (ifa.out_valid !== 1'b1) begin n_fail++; $display("FAIL rm_fresh_valid: got %b want 1", ifa.out_valid); end
    if (ifa.q !== 8'h03)        begin n_fail++; $display("FAIL rm_fresh_q: got %h want 03", ifa.q); end
    tick();
  endtask

  task automatic test_narrow();
    logic [7:0] e;
    ifb.out_ready = 1'b1;
    ifb.in_valid = 1'b1; ifb.a = 1'b1; ifb.b = 1'b1; ifb.op = 2'b00;
    #1;
    n_tests++;
    if (ifb.in_ready !== 1'b1) begin n_fail++; $display("FAIL nb_in_ready: got %b want 1", ifb.in_ready); end
    tick();
    ifb.in_valid = 1'b0;
    n_tests += 2;
    if (ifb.out_valid !== 1'b1) begin n_fail++; $display("FAIL nb_out_valid: got %b want 1", ifb.out_valid); end
    if (ifb.q !== 1'b1)         begin n_fail++; $display("FAIL nb_q: got %b want 1", ifb.q); end
    for (int i = 0; i < 8; i++) begin
      ifb.in_valid = 1'b1;
      ifb.a = 1'($urandom_range(0, 1)); ifb.b = 1'($urandom_range(0, 1)); ifb.op = 2'($urandom_range(0, 3));
      e = model8({7'd0, ifb.a}, {7'd0, ifb.b}, ifb.op);
      #1;
      n_tests++;
      if (ifb.in_ready !== 1'b1) begin n_fail++; $display("FAIL nb_tp_ready[%0d]: got %b want 1", i, ifb.in_ready); end
      tick();
      n_tests++;
      if (ifb.out_valid !== 1'b1 || ifb.q !== e[0]) begin
        n_fail++; $display("FAIL nb_tp[%0d]: got valid=%b q=%b want valid=1 q=%b", i, ifb.out_valid, ifb.q, e[0]);
      end
    end
    ifb.in_valid = 1'b0;
    tick();
    n_tests++;
    if (ifb.out_valid !== 1'b0) begin n_fail++; $display("FAIL nb_idle: got out_valid=%b want 0", ifb.out_valid); end
    // Single-entry stall: full slot blocks input until the consumer takes it.
    ifb.out_ready = 1'b0;
    ifb.in_valid = 1'b1; ifb.a = 1'b0; ifb.b = 1'b1; ifb.op = 2'b01;
    tick();
    ifb.a = 1'b1; ifb.b = 1'b1; ifb.op = 2'b11;
    for (int k = 0; k < 2; k++) begin
      #1;
      n_tests += 2;
      if (ifb.in_ready !== 1'b0) begin n_fail++; $display("FAIL nb_stall_ready[%0d]: got %b want 0", k, ifb.in_ready); end
      if (ifb.q !== 1'b1)        begin n_fail++; $display("FAIL nb_stall_q[%0d]: got %b want 1", k, ifb.q); end
      tick();
    end
    ifb.out_ready = 1'b1;
    #1;
    n_tests++;
    if (ifb.in_ready !== 1'b1) begin n_fail++; $display("FAIL nb_pass_ready: got %b want 1", ifb.in_ready); end
    tick();
    ifb.in_valid = 1'b0;
    n_tests++;
    if (ifb.q !== 1'b0) begin n_fail++; $display("FAIL nb_second: got %b want 0", ifb.q); end
    tick();
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    rst = 1'b1;
    ifa.a = '0; ifa.b = '0; ifa.op = '0; ifa.in_valid = 1'b0; ifa.out_ready = 1'b1;
    ifb.a = '0; ifb.b = '0; ifb.op = '0; ifb.in_valid = 1'b0; ifb.out_ready = 1'b1;
    test_reset();
    test_ops();
    test_backpressure();
    test_zero_count();
    test_reset_mid();
    test_narrow();
    tick(); tick();
    n_tests++;
    if (qa.size() != 0 || qb.size() != 0) begin
      n_fail++; $display("FAIL sb_leftover: got %0d/%0d undelivered want 0/0", qa.size(), qb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish within 200000 time units");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/logic_pipe_reg.md
Name: logic_pipe_reg

Overview:
Parametrised successor to the single-bit registered AND flop. Computes a selectable bitwise function of two WIDTH-bit operands and carries the result through STAGES elastic register stages with valid/ready handshaking. Also keeps a saturating count of delivered all-zero results. Sits between a producer and a consumer that may both stall; used as a generic registered logic/retiming element.

Parameters:
WIDTH, 8, operand and result width in bits (>=1)
STAGES, 2, number of register stages, i.e. latency in cycles (>=1)
CNT_W, 16, width of zero-result counter (>=1)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
a  input  WIDTH  operand A
b  input  WIDTH  operand B
op  input  2  function select: 00 AND, 01 OR, 10 XOR, 11 NAND
in_valid  input  1  producer presents a/b/op
in_ready  output  1  block accepts a/b/op this cycle
q  output  WIDTH  result at final stage
out_valid  output  1  q holds a valid result
out_ready  input  1  consumer accepts q this cycle
zero_cnt  output  CNT_W  saturating count of delivered results equal to zero

Behaviour:
- Reset (async assert, synchronous-safe deassert by design): all stage valid bits 0, all stage data 0, zero_cnt 0. Hence q=0, out_valid=0, in_ready=1 while rst high and on the first cycle after release.
- Function is evaluated combinationally from a/b/op at acceptance. Only the result is registered; op is not stored. NAND = ~(a&b) on all WIDTH bits.
- Accept: a transfer into stage 0 occurs when in_valid && in_ready.
- Stage i advance rule: stage i loads from stage i-1 (or the input for i=0) when it is empty or when it is emptying this cycle. Stage STAGES-1 empties when out_valid && out_ready; stage i<STAGES-1 empties when it moves into stage i+1.
- in_ready = !valid[0] || stage 0 emptying. This is combinational from out_ready through the chain (a full pipeline with out_ready=1 accepts every cycle).
- Throughput: one result per cycle with no backpressure. Latency: a result accepted at edge N is presented with out_valid=1 after edge N+STAGES-1 (STAGES=1: visible right after the accepting edge).
- Bubbles collapse: an empty stage loads even if downstream is stalled.
- Data in a stage whose valid=0 is don't-care but must not be counted or delivered. Data holds stable while valid=1 and not advancing; q and out_valid are stable under stall.
- No reordering, no drops, no duplication. Capacity is exactly STAGES entries.
- zero_cnt increments by 1 on each out_valid && out_ready with q==0 and saturates at 2^CNT_W-1 (no wrap).
- in_valid with in_ready=0: not accepted; the producer must hold. The block does not require a/b stable while unaccepted.
- Reset mid-operation: all in-flight results are discarded immediately and the counter clears; no output transfer occurs while rst is high.

Decomposition:
- Package logic_pipe_pkg: op encoding constants OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_NAND=2'b11, plus a function computing the result from (a, b, op).
- Sub-module logic_pipe_stage: one WIDTH-bit register plus valid bit with upstream valid/ready and downstream valid/ready; the top generates STAGES instances in a chain, adds the stage-0 function, and adds the counter.

Test Plan:
- Reset/idle: rst=1 for 2 cycles, then release -> q=0, out_valid=0, in_ready=1, zero_cnt=0.
- Op coverage, STAGES=2, out_ready=1: a=8'hF0, b=8'h3C with op=00/01/10/11 on consecutive cycles -> q=8'h30, 8'hFC, 8'hCC, 8'hCF in order, each 2 cycles after acceptance, back-to-back out_valid.
- Backpressure: out_ready=0 and stream 3 items -> in_ready drops after 2 accepts; q holds the first result stable; raising out_ready drains all 3 in order with no loss.
- Zero counting and saturation with CNT_W=2: deliver 5 results of a=8'h0F, b=8'hF0, op=AND -> zero_cnt 1,2,3,3,3. A stalled zero result (out_ready=0) does not count.
- Reset mid-flight: fill the pipeline, assert rst asynchronously between edges -> out_valid=0 and zero_cnt=0 immediately; after release no stale results appear.
- STAGES=1 and WIDTH=1 build: a=1, b=1, op=AND -> q=1, out_valid=1 the cycle after acceptance; sustained one-per-cycle throughput with out_ready=1.
